// File: rtl/traffic_lights.sv
// -----------------------------------------------------------------------------
// traffic_lights
//
// Two-way intersection controller. Six phases run in a fixed loop:
//   AR_N -> NS_G -> NS_Y -> AR_E -> EW_G -> EW_Y -> AR_N ...
// All-red phases (AR_N, AR_E) last 2 ticks, yellows last 3 ticks and the
// greens last G ticks, where G is greenLightTime with 0 treated as 1.
// One tick is one clock cycle with ce high; ce low freezes everything.
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst            in   1  synchronous active-high reset, wins over ce
//   ce             in   1  tick enable
//   greenLightTime in   6  green duration in ticks (0 behaves as 1)
//   lights         out  6  {NS red, NS yellow, NS green, EW red, EW yellow, EW green}
//   timeLeftNS     out  8  ticks until the NS lamp colour next changes (bit 7 = 0)
//   timeLeftEW     out  7  ticks until the EW lamp colour next changes
//   dbg_phase_o    out  3  current phase, for observation only
// -----------------------------------------------------------------------------
module traffic_lights (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [5:0] greenLightTime,
    output logic [5:0] lights,
    output logic [7:0] timeLeftNS,
    output logic [6:0] timeLeftEW,
    output logic [2:0] dbg_phase_o
);

    typedef enum logic [2:0] {
        AR_N = 3'd0,
        NS_G = 3'd1,
        NS_Y = 3'd2,
        AR_E = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5
    } phase_t;

    localparam logic [5:0] LAMP_ALL_RED = 6'b100_100;
    localparam logic [5:0] LAMP_NS_G    = 6'b001_100;
    localparam logic [5:0] LAMP_NS_Y    = 6'b010_100;
    localparam logic [5:0] LAMP_EW_G    = 6'b100_001;
    localparam logic [5:0] LAMP_EW_Y    = 6'b100_010;

    localparam logic [5:0] DUR_ALL_RED  = 6'd2;
    localparam logic [5:0] DUR_YELLOW   = 6'd3;

    phase_t     phase_q;
    phase_t     phase_d;
    logic [5:0] cnt_q;
    logic [5:0] cnt_d;
    logic [5:0] lights_q;
    logic [5:0] lights_d;
    logic [5:0] green_time;

    // Zero is not a usable duration; it behaves as the shortest green.
    assign green_time = (greenLightTime == 6'd0) ? 6'd1 : greenLightTime;

    // Successor phase, its load value and its lamp pattern. greenLightTime
    // only matters here at the moment a green phase is entered, so changing
    // it mid-green never stretches or shortens the running phase.
    always_comb begin
        phase_d  = AR_N;
        cnt_d    = DUR_ALL_RED;
        lights_d = LAMP_ALL_RED;
        unique case (phase_q)
            AR_N: begin
                phase_d  = NS_G;
                cnt_d    = green_time;
                lights_d = LAMP_NS_G;
            end
            NS_G: begin
                phase_d  = NS_Y;
                cnt_d    = DUR_YELLOW;
                lights_d = LAMP_NS_Y;
            end
            NS_Y: begin
                phase_d  = AR_E;
                cnt_d    = DUR_ALL_RED;
                lights_d = LAMP_ALL_RED;
            end
            AR_E: begin
                phase_d  = EW_G;
                cnt_d    = green_time;
                lights_d = LAMP_EW_G;
            end
            EW_G: begin
                phase_d  = EW_Y;
                cnt_d    = DUR_YELLOW;
                lights_d = LAMP_EW_Y;
            end
            EW_Y: begin
                phase_d  = AR_N;
                cnt_d    = DUR_ALL_RED;
                lights_d = LAMP_ALL_RED;
            end
            default: begin
                phase_d  = AR_N;
                cnt_d    = DUR_ALL_RED;
                lights_d = LAMP_ALL_RED;
            end
        endcase
    end

    // Phase FSM with registered lamps. cnt_q counts down the ticks left in
    // the current phase; reaching 1 on a tick moves to the next phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= AR_N;
            cnt_q    <= DUR_ALL_RED;
            lights_q <= LAMP_ALL_RED;
        end else if (ce) begin
            if (cnt_q == 6'd1) begin
                phase_q  <= phase_d;
                cnt_q    <= cnt_d;
                lights_q <= lights_d;
            end else begin
                cnt_q <= cnt_q - 6'd1;
            end
        end
    end

    // Time until each direction's colour changes: the remainder of the
    // current phase plus every following phase in which that direction
    // keeps the same colour. Future greens use the live clamped G.
    // Largest result is 2 + 63 + 5 = 70, which fits in 7 bits.
    logic [6:0] cnt_w;
    logic [6:0] g_w;
    logic [6:0] ns_left;
    logic [6:0] ew_left;

    assign cnt_w = {1'b0, cnt_q};
    assign g_w   = {1'b0, green_time};

    always_comb begin
        ns_left = cnt_w;
        ew_left = cnt_w;
        unique case (phase_q)
            AR_N: begin
                ns_left = cnt_w;
                ew_left = cnt_w + g_w + 7'd5;
            end
            NS_G: begin
                ns_left = cnt_w;
                ew_left = cnt_w + 7'd5;
            end
            NS_Y: begin
                ns_left = cnt_w;
                ew_left = cnt_w + 7'd2;
            end
            AR_E: begin
                ns_left = cnt_w + g_w + 7'd5;
                ew_left = cnt_w;
            end
            EW_G: begin
                ns_left = cnt_w + 7'd5;
                ew_left = cnt_w;
            end
            EW_Y: begin
                ns_left = cnt_w + 7'd2;
                ew_left = cnt_w;
            end
            default: begin
                ns_left = cnt_w;
                ew_left = cnt_w;
            end
        endcase
    end

    assign lights      = lights_q;
    assign timeLeftNS  = {1'b0, ns_left};
    assign timeLeftEW  = ew_left;
    assign dbg_phase_o = phase_q;

endmodule

// File: tb/tb_traffic_lights.sv
// -----------------------------------------------------------------------------
// tb_traffic_lights
//
// Reference model: the cycle is a table of six phases (duration and colour
// shown to each direction). The model tracks which table entry is active and
// how many ticks remain; the time-left outputs are found by walking the
// table forward until the direction's colour changes and summing durations.
// -----------------------------------------------------------------------------
module tb_traffic_lights;

    logic       clk;
    logic       rst;
    logic       ce;
    logic [5:0] greenLightTime;
    logic [5:0] lights;
    logic [7:0] timeLeftNS;
    logic [6:0] timeLeftEW;
    logic [2:0] dbg_phase;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // model state
    int m_idx = 0;
    int m_rem = 2;

    traffic_lights dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .greenLightTime (greenLightTime),
        .lights         (lights),
        .timeLeftNS     (timeLeftNS),
        .timeLeftEW     (timeLeftEW),
        .dbg_phase_o    (dbg_phase)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int clamp_g(input logic [5:0] g);
        return (g == 6'd0) ? 1 : int'(g);
    endfunction

    // table order: 0 AR_N, 1 NS_G, 2 NS_Y, 3 AR_E, 4 EW_G, 5 EW_Y
    function automatic int dur(input int i, input int g);
        case (i)
            1, 4:    return g;
            2, 5:    return 3;
            default: return 2;
        endcase
    endfunction

    // colour as lamp triplet {red, yellow, green}
    function automatic logic [2:0] ns_col(input int i);
        if (i == 1) return 3'b001;
        if (i == 2) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ew_col(input int i);
        if (i == 4) return 3'b001;
        if (i == 5) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [5:0] exp_lights();
        return {ns_col(m_idx), ew_col(m_idx)};
    endfunction

    function automatic int exp_ns();
        int t;
        int j;
        t = m_rem;
        j = (m_idx + 1) % 6;
        while (ns_col(j) == ns_col(m_idx)) begin
            t += dur(j, clamp_g(greenLightTime));
            j = (j + 1) % 6;
        end
        return t;
    endfunction

    function automatic int exp_ew();
        int t;
        int j;
        t = m_rem;
        j = (m_idx + 1) % 6;
        while (ew_col(j) == ew_col(m_idx)) begin
            t += dur(j, clamp_g(greenLightTime));
            j = (j + 1) % 6;
        end
        return t;
    endfunction

    // one clock: drive at negedge, model follows the rising edge, outputs
    // are then sampled 1 time unit later by the caller
    task automatic step(input logic ce_v, input logic rst_v);
        @(negedge clk);
        ce  = ce_v;
        rst = rst_v;
        @(posedge clk);
        if (rst_v) begin
            m_idx = 0;
            m_rem = 2;
        end else if (ce_v) begin
            if (m_rem == 1) begin
                m_idx = (m_idx + 1) % 6;
                m_rem = dur(m_idx, clamp_g(greenLightTime));
            end else begin
                m_rem = m_rem - 1;
            end
        end
        #1;
    endtask

    task automatic set_green(input logic [5:0] g);
        @(negedge clk);
        greenLightTime = g;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_green(6'd15);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        total_cnt++;
        if (lights !== 6'b100100) $display("FAIL reset_lights: got %b want %b", lights, 6'b100100);
        else pass_cnt++;
        total_cnt++;
        if (timeLeftNS !== 8'd2) $display("FAIL reset_ns: got %0d want 2", timeLeftNS);
        else pass_cnt++;
        total_cnt++;
        if (timeLeftEW !== 7'd22) $display("FAIL reset_ew: got %0d want 22", timeLeftEW);
        else pass_cnt++;
    endtask

    task automatic test_full_cycle();
        logic [5:0] want_l;
        int want_ns;
        int want_ew;
        bit directed;
        for (int t = 1; t <= 40; t++) begin
            step(1'b1, 1'b0);
            directed = 1'b1;
            case (t)
                2:       begin want_l = 6'b001100; want_ns = 15; want_ew = 20; end
                17:      begin want_l = 6'b010100; want_ns = 3;  want_ew = 5;  end
                20:      begin want_l = 6'b100100; want_ns = 22; want_ew = 2;  end
                22:      begin want_l = 6'b100001; want_ns = 20; want_ew = 15; end
                40:      begin want_l = 6'b100100; want_ns = 2;  want_ew = 22; end
                default: begin want_l = 6'b0; want_ns = 0; want_ew = 0; directed = 1'b0; end
            endcase
            if (directed) begin
                total_cnt++;
                if (lights !== want_l || int'(timeLeftNS) != want_ns || int'(timeLeftEW) != want_ew)
                    $display("FAIL cycle_tick%0d: got l=%b ns=%0d ew=%0d want l=%b ns=%0d ew=%0d",
                             t, lights, timeLeftNS, timeLeftEW, want_l, want_ns, want_ew);
                else pass_cnt++;
            end
            total_cnt++;
            if (!$onehot(lights[5:3]) || !$onehot(lights[2:0]) || (lights[4:3] != 2'b00 && lights[1:0] != 2'b00))
                $display("FAIL cycle_onehot: got %b at tick %0d want one lamp per direction", lights, t);
            else pass_cnt++;
            total_cnt++;
            if (lights !== exp_lights() || int'(timeLeftNS) != exp_ns() || int'(timeLeftEW) != exp_ew())
                $display("FAIL cycle_model: tick %0d got l=%b ns=%0d ew=%0d want l=%b ns=%0d ew=%0d",
                         t, lights, timeLeftNS, timeLeftEW, exp_lights(), exp_ns(), exp_ew());
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        logic [5:0] l0;
        logic [7:0] ns0;
        logic [6:0] ew0;
        set_green(6'd15);
        step(1'b1, 1'b1);
        for (int t = 0; t < 6; t++) step(1'b1, 1'b0);   // 4 ticks into NS_G
        l0  = lights;
        ns0 = timeLeftNS;
        ew0 = timeLeftEW;
        total_cnt++;
        if (lights !== 6'b001100 || timeLeftNS !== 8'd11 || timeLeftEW !== 7'd16)
            $display("FAIL hold_entry: got l=%b ns=%0d ew=%0d want l=001100 ns=11 ew=16",
                     lights, timeLeftNS, timeLeftEW);
        else pass_cnt++;
        for (int t = 0; t < 50; t++) step(1'b0, 1'b0);
        total_cnt++;
        if (lights !== l0 || timeLeftNS !== ns0 || timeLeftEW !== ew0)
            $display("FAIL hold_frozen: got l=%b ns=%0d ew=%0d want l=%b ns=%0d ew=%0d",
                     lights, timeLeftNS, timeLeftEW, l0, ns0, ew0);
        else pass_cnt++;
        for (int t = 0; t < 12; t++) begin
            step(1'b1, 1'b0);
            total_cnt++;
            if (lights !== exp_lights() || int'(timeLeftNS) != exp_ns() || int'(timeLeftEW) != exp_ew())
                $display("FAIL hold_resume: got l=%b ns=%0d ew=%0d want l=%b ns=%0d ew=%0d",
                         lights, timeLeftNS, timeLeftEW, exp_lights(), exp_ns(), exp_ew());
            else pass_cnt++;
        end
        total_cnt++;
        if (lights !== 6'b010100) $display("FAIL hold_to_yellow: got %b want 010100", lights);
        else pass_cnt++;
    endtask

    task automatic test_green_zero();
        set_green(6'd0);
        step(1'b1, 1'b1);
        total_cnt++;
        if (timeLeftEW !== 7'd8) $display("FAIL g0_reset_ew: got %0d want 8", timeLeftEW);
        else pass_cnt++;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        total_cnt++;
        if (lights !== 6'b001100 || timeLeftNS !== 8'd1)
            $display("FAIL g0_ns_green: got l=%b ns=%0d want l=001100 ns=1", lights, timeLeftNS);
        else pass_cnt++;
        step(1'b1, 1'b0);
        total_cnt++;
        if (lights !== 6'b010100) $display("FAIL g0_ns_green_len: got %b want 010100", lights);
        else pass_cnt++;
        for (int t = 0; t < 5; t++) step(1'b1, 1'b0);
        total_cnt++;
        if (lights !== 6'b100001 || timeLeftEW !== 7'd1)
            $display("FAIL g0_ew_green: got l=%b ew=%0d want l=100001 ew=1", lights, timeLeftEW);
        else pass_cnt++;
        step(1'b1, 1'b0);
        total_cnt++;
        if (lights !== 6'b100010) $display("FAIL g0_ew_green_len: got %b want 100010", lights);
        else pass_cnt++;
    endtask

    task automatic test_green_change();
        set_green(6'd10);
        step(1'b1, 1'b1);
        for (int t = 1; t <= 21; t++) begin
            if (t == 6) greenLightTime = 6'd4;   // changed while NS_G is running
            step(1'b1, 1'b0);
            if (t == 11 || t == 12 || t == 17 || t == 20 || t == 21) begin
                total_cnt++;
                if ((t == 11 && lights !== 6'b001100) || (t == 12 && lights !== 6'b010100) ||
                    (t == 17 && lights !== 6'b100001) || (t == 20 && lights !== 6'b100001) ||
                    (t == 21 && lights !== 6'b100010))
                    $display("FAIL gchange_tick%0d: got %b want %b", t, lights, exp_lights());
                else pass_cnt++;
            end
            total_cnt++;
            if (lights !== exp_lights() || int'(timeLeftNS) != exp_ns() || int'(timeLeftEW) != exp_ew())
                $display("FAIL gchange_model: tick %0d got l=%b ns=%0d ew=%0d want l=%b ns=%0d ew=%0d",
                         t, lights, timeLeftNS, timeLeftEW, exp_lights(), exp_ns(), exp_ew());
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_ewg();
        set_green(6'd15);
        step(1'b1, 1'b1);
        for (int t = 0; t < 25; t++) step(1'b1, 1'b0);   // 3 ticks into EW_G
        total_cnt++;
        if (lights !== 6'b100001) $display("FAIL rst_mid_pre: got %b want 100001", lights);
        else pass_cnt++;
        step(1'b1, 1'b1);
        total_cnt++;
        if (lights !== 6'b100100 || timeLeftNS !== 8'd2 || timeLeftEW !== 7'd22)
            $display("FAIL rst_mid_post: got l=%b ns=%0d ew=%0d want l=100100 ns=2 ew=22",
                     lights, timeLeftNS, timeLeftEW);
        else pass_cnt++;
        step(1'b1, 1'b1);
        total_cnt++;
        if (lights !== 6'b100100 || timeLeftNS !== 8'd2)
            $display("FAIL rst_held: got l=%b ns=%0d want l=100100 ns=2", lights, timeLeftNS);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic ce_v;
        logic rst_v;
        step(1'b1, 1'b1);
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0:       greenLightTime = 6'd0;
                    1:       greenLightTime = 6'd63;
                    default: greenLightTime = 6'($urandom_range(0, 63));
                endcase
            end
            ce_v  = ($urandom_range(0, 3) != 0);
            rst_v = ($urandom_range(0, 149) == 0);
            step(ce_v, rst_v);
            total_cnt++;
            if (lights !== exp_lights() || int'(timeLeftNS) != exp_ns() || int'(timeLeftEW) != exp_ew() ||
                timeLeftNS[7] !== 1'b0)
                $display("FAIL random: cyc %0d got l=%b ns=%0d ew=%0d want l=%b ns=%0d ew=%0d",
                         t, lights, timeLeftNS, timeLeftEW, exp_lights(), exp_ns(), exp_ew());
            else pass_cnt++;
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1;
        ce = 1'b0;
        greenLightTime = 6'd15;
        test_reset();
        test_full_cycle();
        test_hold();
        test_green_zero();
        test_green_change();
        test_reset_mid_ewg();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/traffic_lights.md
TRAFFIC_LIGHTS -- requirements
Module: traffic_lights

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (ports clk and rst).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset; priority over ce.
REQ-004 ce  input  1  tick enable; one asserted-ce cycle = one timing tick; ce=0 holds all state.
REQ-005 lights  output  6  lamp vector: [5] NS red, [4] NS yellow, [3] NS green, [2] EW red, [1] EW yellow, [0] EW green.
REQ-006 greenLightTime  input  6  green phase duration in ticks, 1..63; value 0 SHALL be treated as 1.
REQ-007 timeLeftNS  output  8  ticks remaining until the NS lamp colour next changes; bit 7 always 0.
REQ-008 timeLeftEW  output  7  ticks remaining until the EW lamp colour next changes.

Function
REQ-009 The block SHALL cycle through six phases in a fixed order: AR_N, NS_G, NS_Y, AR_E, EW_G, EW_Y, then back to AR_N.
REQ-010 Phase durations SHALL be as follows: AR_N=2, NS_Y=3, AR_E=2, EW_Y=3; NS_G and EW_G use G = clamped greenLightTime.
REQ-011 Lamps per phase SHALL be: AR_N/AR_E -> 100100; NS_G -> 001100; NS_Y -> 010100; EW_G -> 100001; EW_Y -> 100010.
REQ-012 Each direction SHALL have exactly one lamp lit in every phase; green or yellow never lit on both directions simultaneously.
REQ-013 A phase counter cnt SHALL hold remaining ticks in current phase, range 1..max duration.
REQ-014 On clk edge with ce=1: if cnt==1, advance to next phase and load cnt with that phase's duration; else cnt decrements by 1.
REQ-015 On clk edge with ce=0 and rst=0: phase, cnt and all outputs SHALL hold.
REQ-016 greenLightTime SHALL be sampled only when loading cnt on entry to NS_G or EW_G; mid-phase changes do not alter the current phase.
REQ-017 timeLeftNS SHALL be combinational from phase and cnt: AR_N/NS_G/NS_Y -> cnt; AR_E -> cnt+G+5; EW_G -> cnt+5; EW_Y -> cnt+2.
REQ-018 timeLeftEW SHALL be: AR_E/EW_G/EW_Y -> cnt; AR_N -> cnt+G+5; NS_G -> cnt+5; NS_Y -> cnt+2.
REQ-019 G in REQ-017/018 SHALL be current clamped greenLightTime; max value 70 fits both widths without overflow.
REQ-020 A full cycle SHALL be 2*G+10 ticks; the counter wraps from EW_Y back to AR_N with no idle cycle.
REQ-021 Before the first reset, state is undefined; no requirement applies until rst has been asserted.

Reset
REQ-022 rst=1 at a clk edge SHALL force phase=AR_N, cnt=2, regardless of ce or current phase (including mid-phase).
REQ-023 After reset, lights SHALL be 100100, timeLeftNS=2, timeLeftEW=G+7.
REQ-024 While rst=1, the state SHALL remain at its reset value even with ce=1.

Verification
REQ-025 G=15, rst pulse, ce=1 -> lights=100100, timeLeftNS=2, timeLeftEW=22; after 2 ticks lights=001100, NS=15, EW=20.
REQ-026 G=15, after 17 ticks from reset -> lights=010100, NS=3, EW=5; after 20 ticks -> 100100, NS=22, EW=2; after 22 ticks -> 100001, NS=20, EW=15.
REQ-027 G=15, after 40 ticks from reset -> back to AR_N (100100, NS=2, EW=22); period 40 ticks, each direction one-hot every cycle.
REQ-028 ce=0 for 50 cycles mid-NS_G -> lights, timeLeftNS, timeLeftEW unchanged; resumes correctly when ce=1.
REQ-029 greenLightTime=0 -> green phases last 1 tick; greenLightTime changed mid-NS_G -> current green length unchanged, next EW_G uses new value.
REQ-030 rst asserted during EW_G with ce=1 -> next edge lights=100100, timeLeftNS=2.
